// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester and the slave models.
package apb_pkg;

  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: single-beat commands in, SETUP/ACCESS transfers out,
// one-entry response register with a programmable wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero timeout still needs a one-bit counter so the logic stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  rsp_t                  rsp_q, rsp_d;

  logic                  cmd_fire;
  logic [CNT_W-1:0]      wait_inc;
  logic                  timeout_hit;

  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

  // Next-state, wait counter and response loading for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    wait_inc    = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == CNT_LIMIT);

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          wait_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
          rsp_d.slverr  = PSLVERR;
          rsp_d.timeout = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) begin
            rsp_d.rdata   = '0;
            rsp_d.slverr  = 1'b1;
            rsp_d.timeout = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bus and response registers; reset drops any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers against a transaction-level memory model.
module tb_apb_master;

  localparam int TMO = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  // Slave configuration for the current transfer and its storage.
  int          cur_waits = 0;
  logic        cur_err = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] init_mem [16];
  logic [31:0] slave_mem [16];
  bit          written [16];
  logic [31:0] model_mem [16];

  apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  // Free-running bus clock.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= cur_waits);
  assign PSLVERR = PREADY && cur_err;
  assign PRDATA  = (PREADY && !PWRITE) ?
                   (written[PADDR[5:2]] ? slave_mem[PADDR[5:2]] : init_mem[PADDR[5:2]]) : 32'h0;

  // Slave model: counts wait states and commits error-free writes.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PREADY && PWRITE && !cur_err) begin
      slave_mem[PADDR[5:2]] <= PWDATA;
      written[PADDR[5:2]]   <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at #1 after an edge and wait (bounded) for acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input logic err);
    bit acc = 0;
    cur_waits = waits;
    cur_err   = err;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge PCLK);
      if (cmd_ready) acc = 1;
      @(posedge PCLK);
    end
    #1 cmd_valid = 1'b0;
    if (!acc) checkOutput("accept_bound", 0, 1);
  endtask

  // From #1 after the acceptance edge, follow the transfer to its response
  // and compare against the transaction-level expectation.
  task automatic waitResponse(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic err);
    bit          is_to   = (waits >= TMO);
    int          acc_cyc = is_to ? TMO : waits + 1;
    int          idx     = int'(addr[5:2]);
    logic [31:0] exp_rd  = (wr || is_to) ? 32'h0 : model_mem[idx];
    logic        exp_err = is_to ? 1'b1 : err;
    int          edges = 0, psel_cyc = 0, pen_cyc = 0, unstable = 0;
    bit          done = 0;
    if (wr && !is_to && !err) model_mem[idx] = wdata;
    while (!done && edges < 20) begin
      @(negedge PCLK);
      if (rsp_valid) done = 1;
      else begin
        if (PSEL) begin
          psel_cyc++;
          if (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata)) unstable++;
        end
        if (PENABLE) pen_cyc++;
        @(posedge PCLK);
        edges++;
      end
    end
    checkOutput("rsp_seen", done, 1);
    checkOutput("latency", edges, 1 + acc_cyc);
    checkOutput("psel_cycles", psel_cyc, 1 + acc_cyc);
    checkOutput("penable_cycles", pen_cyc, acc_cyc);
    checkOutput("bus_stable", unstable, 0);
    checkOutput("psel_after", PSEL, 0);
    checkOutput("rsp_rdata", rsp_rdata, exp_rd);
    checkOutput("rsp_slverr", rsp_slverr, exp_err);
    checkOutput("rsp_timeout", rsp_timeout, is_to);
  endtask

  // From a negedge with a response pending, hold it, then drain it.
  task automatic drainResponse(input int hold);
    logic [31:0] rd = rsp_rdata;
    repeat (hold) begin
      @(posedge PCLK);
      @(negedge PCLK);
      checkOutput("rsp_hold_valid", rsp_valid, 1);
      checkOutput("rsp_hold_data", rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 rsp_ready = 1'b0;
    checkOutput("rsp_drained", rsp_valid, 0);
  endtask

  task automatic runTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic err, input int hold);
    applyStimulus(wr, addr, wdata, waits, err);
    waitResponse(wr, addr, wdata, waits, err);
    drainResponse(hold);
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr, data;
    int          waits;
    logic        err;

    for (int i = 0; i < 16; i++) begin
      init_mem[i]  = $urandom;
      model_mem[i] = init_mem[i];
    end
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_pwrite", PWRITE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_flags", {rsp_slverr, rsp_timeout}, 0);
    PRESETn = 1'b1;
    #1 checkOutput("rst_cmd_ready", cmd_ready, 1);
    @(posedge PCLK);
    #1;

    $display("[TB] directed transfers");
    runTxn(1'b1, 32'h10, 32'hDEAD_BEEF, 1, 1'b0, 0);
    runTxn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0);
    runTxn(1'b0, 32'h14, 32'h0, 100, 1'b0, 0);
    runTxn(1'b0, 32'h20, 32'h0, 0, 1'b1, 1);

    $display("[TB] response backpressure");
    applyStimulus(1'b1, 32'h24, 32'hCAFE_0001, 0, 1'b0);
    waitResponse(1'b1, 32'h24, 32'hCAFE_0001, 0, 1'b0);
    cur_waits = 0;
    cur_err   = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h24;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge PCLK);
      @(negedge PCLK);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_psel", PSEL, 0);
      checkOutput("bp_rsp_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    #1 checkOutput("bp_ready_on_drain", cmd_ready, 1);
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("bp_setup_psel", PSEL, 1);
    checkOutput("bp_setup_penable", PENABLE, 0);
    checkOutput("bp_rsp_cleared", rsp_valid, 0);
    waitResponse(1'b0, 32'h24, 32'h0, 0, 1'b0);
    drainResponse(0);

    $display("[TB] reset during access");
    applyStimulus(1'b1, 32'h30, 32'h1234_5678, 3, 1'b0);
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("mid_in_access", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_psel", PSEL, 0);
    checkOutput("mid_rst_penable", PENABLE, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(posedge PCLK);
    #1 checkOutput("mid_no_rsp", rsp_valid, 0);
    runTxn(1'b0, 32'h30, 32'h0, 0, 1'b0, 0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 16; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 15)) << 2;
      data  = $urandom;
      waits = int'($urandom_range(0, 5));
      err   = ($urandom_range(0, 3) == 0);
      runTxn(wr, addr, data, waits, err, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
